// File: rtl/falafel_pkg.sv
// Shared falafel types: LSU header request/response, LSU op codes and the
// LSU arbiter state encoding.
package falafel_pkg;

    localparam int FALAFEL_ARB_N_REQ_DEFAULT = 2;
    localparam int HDR_DW                    = 32;

    typedef enum logic [2:0] {
        LOCK   = 3'd0,
        UNLOCK = 3'd1,
        LOAD   = 3'd2,
        INSERT = 3'd3,
        DELETE = 3'd4
    } req_lsu_op_e;

    typedef struct packed {
        logic              val;
        req_lsu_op_e       lsu_op;
        logic [HDR_DW-1:0] header_data;
    } header_data_req_t;

    typedef struct packed {
        logic              val;
        logic [HDR_DW-1:0] header_data;
    } header_data_rsp_t;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_OWNED    = 2'd1,
        ARB_WAIT_RSP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/falafel_lsu_arbiter_rr_picker.sv
// Round-robin picker: first set candidate at or after ptr_i, wrapping modulo N.
// Purely combinational.
module falafel_rr_picker #(
    parameter  int N   = 2,
    localparam int IW  = $clog2(N),
    localparam int IW1 = IW + 1
) (
    input  logic [N-1:0]  cand_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW1-1:0] off;
    logic [IW1-1:0] sum;

    // rot[k] is the candidate k places after the pointer
    assign dbl = {cand_i, cand_i} >> ptr_i;
    assign rot = dbl[N-1:0];

    // scan from the far end so the closest candidate to the pointer wins
    always_comb begin
        valid_o = 1'b0;
        off     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid_o = 1'b1;
                off     = IW1'(k);
            end
        end
        sum = {1'b0, ptr_i} + off;
        if (sum >= IW1'(N)) sum = sum - IW1'(N);
        idx_o = sum[IW-1:0];
    end

endmodule

// File: rtl/falafel_lsu_arbiter.sv
// LSU arbiter: shares one header LSU port between N_REQ requesters in whole
// LOCK..UNLOCK sessions, round-robin among LOCK requesters, one transaction in
// flight, responses routed combinationally to the session owner.
// Optional lock-hold monitor enabled by FALAFEL_ARB_TIMEOUT_EN.
module falafel_lsu_arbiter
    import falafel_pkg::*;
#(
    parameter  int N_REQ        = FALAFEL_ARB_N_REQ_DEFAULT,
    parameter  int LOCK_TIMEOUT = 1024,
    localparam int IDW          = $clog2(N_REQ)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  header_data_req_t [N_REQ-1:0]       req_i,
    output logic             [N_REQ-1:0]       req_ready_o,
    output header_data_rsp_t [N_REQ-1:0]       rsp_o,
    output header_data_req_t                   req_to_lsu_o,
    input  logic                               lsu_ready_i,
    input  header_data_rsp_t                   rsp_from_lsu_i,
    output logic                               busy_o,
    output logic             [IDW-1:0]         owner_o,
    output logic                               lock_timeout_o
);

    arb_state_e   state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    req_lsu_op_e  pend_op_q, pend_op_d;

    logic [N_REQ-1:0] cand;
    logic             pick_vld;
    logic [IDW-1:0]   pick_idx;

    // only LOCK requests may open a session
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            cand[i] = req_i[i].val && (req_i[i].lsu_op == LOCK);
        end
    end

    falafel_rr_picker #(.N(N_REQ)) u_picker (
        .cand_i  (cand),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_vld),
        .idx_o   (pick_idx)
    );

    // request/response muxing and session FSM next state
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        pend_op_d    = pend_op_q;
        req_to_lsu_o = '0;
        req_ready_o  = '0;
        rsp_o        = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    req_to_lsu_o          = req_i[pick_idx];
                    req_ready_o[pick_idx] = lsu_ready_i;
                    if (lsu_ready_i) begin
                        owner_d   = pick_idx;
                        pend_op_d = LOCK;
                        state_d   = ARB_WAIT_RSP;
                    end
                end
            end
            ARB_OWNED: begin
                // ready is not gated by val so cores may gate val on ready
                req_to_lsu_o         = req_i[owner_q];
                req_ready_o[owner_q] = lsu_ready_i;
                if (req_i[owner_q].val && lsu_ready_i) begin
                    pend_op_d = req_i[owner_q].lsu_op;
                    state_d   = ARB_WAIT_RSP;
                end
            end
            ARB_WAIT_RSP: begin
                rsp_o[owner_q] = rsp_from_lsu_i;
                if (rsp_from_lsu_i.val) begin
                    if (pend_op_q == UNLOCK) begin
                        rr_ptr_d = (owner_q == IDW'(N_REQ - 1)) ? '0 : owner_q + IDW'(1);
                        state_d  = ARB_IDLE;
                    end else begin
                        state_d  = ARB_OWNED;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // session state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB_IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            pend_op_q <= UNLOCK;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            pend_op_q <= pend_op_d;
        end
    end

    assign busy_o  = (state_q != ARB_IDLE);
    assign owner_o = owner_q;

`ifdef FALAFEL_ARB_TIMEOUT_EN
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tflag_q, tflag_d;
    logic          sess_start;

    assign sess_start = (state_q == ARB_IDLE) && (state_d == ARB_WAIT_RSP);

    // saturating hold counter; flag is sticky until reset
    always_comb begin
        tcnt_d  = tcnt_q;
        tflag_d = tflag_q;
        if (sess_start) begin
            tcnt_d = '0;
        end else if (busy_o && (tcnt_q != TW'(LOCK_TIMEOUT))) begin
            tcnt_d = tcnt_q + TW'(1);
        end
        if (tcnt_d == TW'(LOCK_TIMEOUT)) tflag_d = 1'b1;
    end

    // lock-hold monitor registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tcnt_q  <= '0;
            tflag_q <= 1'b0;
        end else begin
            tcnt_q  <= tcnt_d;
            tflag_q <= tflag_d;
        end
    end

    assign lock_timeout_o = tflag_q;
`else
    // monitor absent: LOCK_TIMEOUT is positive, so this is a constant 0
    assign lock_timeout_o = (LOCK_TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_falafel_lsu_arbiter.sv
// Scoreboard bench for falafel_lsu_arbiter: requester tasks push expected
// requests, a monitor keeps a session-level reference model and compares
// every cycle, an LSU model answers with a fixed transform of the data.
module tb_falafel_lsu_arbiter;
    import falafel_pkg::*;

    localparam int N = 2;
`ifdef FALAFEL_ARB_TIMEOUT_EN
    localparam int LT = 16;
`else
    localparam int LT = 1024;
`endif
    localparam logic [31:0] XK = 32'hA5A5_5A5A;

    logic clk = 1'b0;
    logic rst_n;
    header_data_req_t         req_drv [N];
    header_data_req_t [N-1:0] req;
    logic [N-1:0]             rdy;
    header_data_rsp_t [N-1:0] rsp;
    header_data_req_t         to_lsu;
    logic                     lsu_ready;
    header_data_rsp_t         from_lsu;
    logic                     busy;
    logic [0:0]               owner;
    logic                     tmo;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) req[i] = req_drv[i];
    end

    falafel_lsu_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(LT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_ready_o(rdy), .rsp_o(rsp),
        .req_to_lsu_o(to_lsu), .lsu_ready_i(lsu_ready), .rsp_from_lsu_i(from_lsu),
        .busy_o(busy), .owner_o(owner), .lock_timeout_o(tmo)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    header_data_req_t sb_req [N][$];
    logic [31:0]      sb_rsp [N][$];
    int               grant_log[$];

    int  lsu_lat  = 2;
    bit  rdy_rand = 0;
    bit  spur_req = 0;

    // reference model: who owns the lock, whether a transaction is in flight
    initial begin
        int m_own, m_last, m_rr, ei, j;
        bit m_wait;
        req_lsu_op_e m_pend;
        header_data_req_t e_lsu;
        logic [N-1:0] e_rdy;
        header_data_rsp_t [N-1:0] e_rsp;
        m_own = -1; m_last = 0; m_rr = 0; m_wait = 0; m_pend = UNLOCK;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_own = -1; m_last = 0; m_rr = 0; m_wait = 0; m_pend = UNLOCK;
                for (int i = 0; i < N; i++) begin
                    sb_req[i].delete();
                    sb_rsp[i].delete();
                end
                grant_log.delete();
            end else begin
                ei = -1; e_lsu = '0; e_rdy = '0; e_rsp = '0;
                if (m_own < 0) begin
                    for (int k = 0; k < N; k++) begin
                        j = (m_rr + k) % N;
                        if (ei < 0 && req_drv[j].val && req_drv[j].lsu_op == LOCK) ei = j;
                    end
                end else if (!m_wait) begin
                    ei = m_own;
                end
                if (ei >= 0) begin
                    e_lsu = req_drv[ei];
                    e_rdy[ei] = lsu_ready;
                end
                if (m_wait) e_rsp[m_own] = from_lsu;
                chk("busy", busy, m_own >= 0);
                chk("owner", owner, m_last);
                chk("ready", rdy, e_rdy);
                chk("to_lsu", to_lsu, e_lsu);
                chk("rsp", rsp, e_rsp);
`ifndef FALAFEL_ARB_TIMEOUT_EN
                chk("tmo", tmo, 0);
`endif
                for (int i = 0; i < N; i++) begin
                    if (rsp[i].val) begin
                        chk("rsp_pending", sb_rsp[i].size() != 0, 1);
                        if (sb_rsp[i].size() != 0) chk("rsp_data", rsp[i].header_data, sb_rsp[i].pop_front());
                    end
                end
                if (ei >= 0 && req_drv[ei].val && lsu_ready) begin
                    if (m_own < 0) grant_log.push_back(ei);
                    chk("req_pending", sb_req[ei].size() != 0, 1);
                    if (sb_req[ei].size() != 0) chk("sb_req", to_lsu, sb_req[ei].pop_front());
                    sb_rsp[ei].push_back(req_drv[ei].header_data ^ XK);
                    m_own = ei; m_last = ei; m_wait = 1; m_pend = req_drv[ei].lsu_op;
                end else if (m_wait && from_lsu.val) begin
                    m_wait = 0;
                    if (m_pend == UNLOCK) begin
                        m_rr = (m_own + 1) % N;
                        m_own = -1;
                    end
                end
            end
        end
    end

    // LSU model: one transaction at a time, answers data ^ XK after lsu_lat cycles
    initial begin
        bit pend;
        int cnt;
        logic [31:0] pd;
        pend = 0; cnt = 0; pd = '0;
        from_lsu = '0; lsu_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && to_lsu.val && lsu_ready) begin
                pend = 1; pd = to_lsu.header_data ^ XK; cnt = lsu_lat - 1;
            end
            @(posedge clk); #1;
            from_lsu = '0;
            if (!rst_n) pend = 0;
            else if (pend) begin
                if (cnt == 0) begin
                    from_lsu.val = 1'b1; from_lsu.header_data = pd; pend = 0;
                end else cnt--;
            end else if (spur_req) begin
                from_lsu.val = 1'b1; from_lsu.header_data = $urandom; spur_req = 0;
            end
            lsu_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic issue(input int i, input req_lsu_op_e op, output bit ok);
        header_data_req_t r;
        r.val = 1'b1; r.lsu_op = op; r.header_data = $urandom;
        @(posedge clk); #1;
        req_drv[i] = r;
        sb_req[i].push_back(r);
        ok = 0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            if (rdy[i]) ok = 1;
        end
        chk("accept_wait", ok, 1);
        @(posedge clk); #1;
        req_drv[i] = '0;
    endtask

    task automatic do_req(input int i, input req_lsu_op_e op);
        bit ok, got;
        issue(i, op, ok);
        if (ok) begin
            got = 0;
            for (int c = 0; c < 400 && !got; c++) begin
                @(negedge clk);
                if (rsp[i].val) got = 1;
            end
            chk("rsp_wait", got, 1);
        end
    endtask

    task automatic session(input int i, input int nops);
        do_req(i, LOCK);
        for (int k = 0; k < nops; k++) do_req(i, req_lsu_op_e'($urandom_range(2, 4)));
        do_req(i, UNLOCK);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
    endtask

    initial begin
        bit ok;
        header_data_req_t r1;
        for (int i = 0; i < N; i++) req_drv[i] = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_tmo", tmo, 0);
        chk("rst_ready", rdy, 0);
        chk("rst_to_lsu", to_lsu, 0);
        chk("rst_rsp", rsp, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;

        // single requester, 2-cycle LSU
        do_req(0, LOCK);
        do_req(0, LOAD);
        do_req(0, UNLOCK);
        @(negedge clk);
        chk("t1_idle_after_unlock", busy, 0);

        // simultaneous LOCKs after reset
        do_reset();
        fork
            session(0, 1);
            session(1, 1);
        join
        chk("t2_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("t2_first", grant_log[0], 0);
            chk("t2_second", grant_log[1], 1);
        end

        // fairness over 8 sessions with random LSU backpressure/latency
        do_reset();
        rdy_rand = 1;
        lsu_lat = $urandom_range(1, 3);
        fork
            for (int s = 0; s < 4; s++) session(0, $urandom_range(0, 2));
            for (int s = 0; s < 4; s++) session(1, $urandom_range(0, 2));
        join
        rdy_rand = 0;
        lsu_lat = 2;
        chk("t3_grants", grant_log.size(), 8);
        for (int k = 0; k < grant_log.size(); k++) chk("t3_alt", grant_log[k], k % 2);

        // non-owner LOAD during a session, then LOAD while idle
        do_reset();
        do_req(0, LOCK);
        @(posedge clk); #1;
        r1.val = 1'b1; r1.lsu_op = LOAD; r1.header_data = $urandom;
        req_drv[1] = r1;
        sb_req[1].push_back(r1);
        do_req(0, LOAD);
        do_req(0, UNLOCK);
        repeat (10) begin
            @(negedge clk);
            chk("t4_held", {rdy[1], to_lsu.val, busy}, 0);
        end
        @(posedge clk); #1;
        req_drv[1] = '0;
        void'(sb_req[1].pop_back());

        // spurious response while idle
        @(negedge clk);
        spur_req = 1;
        repeat (3) begin
            @(negedge clk);
            chk("t5_spur_rsp", rsp, 0);
        end
        session(0, 1);

        // async reset during WAIT_RSP
        lsu_lat = 8;
        issue(1, LOCK, ok);
        @(negedge clk);
        chk("t5_wait_busy", busy, 1);
        chk("t5_wait_owner", owner, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_arst_busy", busy, 0);
        chk("t5_arst_owner", owner, 0);
        chk("t5_arst_ready", rdy, 0);
        chk("t5_arst_to_lsu", to_lsu, 0);
        chk("t5_arst_rsp", rsp, 0);
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        lsu_lat = 2;
        session(1, 2);

`ifdef FALAFEL_ARB_TIMEOUT_EN
        // long session with the hold monitor
        do_reset();
        do_req(0, LOCK);
        repeat (5) @(negedge clk);
        chk("t6_tmo_early", tmo, 0);
        repeat (15) @(negedge clk);
        chk("t6_tmo_set", tmo, 1);
        do_req(0, UNLOCK);
        repeat (2) @(negedge clk);
        chk("t6_tmo_sticky", tmo, 1);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule
